// File: rtl/wb_timeout_bridge.sv
// wb_timeout_bridge: Wishbone pass-through bridge between the management SoC
// master and the wb_bus decoder.
//
// Every cycle is forwarded combinationally with no added latency. If the
// slave side does not ack within TIMEOUT cycles, the bridge aborts the slave
// cycle, returns a one-cycle error ack carrying ERR_DATA to the master and
// logs the faulting address in sticky status registers.
//
// Optional feature: define WB_TIMEOUT_IRQ_EN to add the registered
// timeout_irq output, which follows the sticky error flag until err_clr.
module wb_timeout_bridge #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] m_adr,
  input  logic [31:0] m_dat_i,
  input  logic [3:0]  m_sel,
  input  logic        m_we,
  input  logic        m_stb,
  input  logic        m_cyc,
  output logic [31:0] m_dat_o,
  output logic        m_ack,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel,
  output logic        s_we,
  output logic        s_stb,
  output logic        s_cyc,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  input  logic        err_clr,
  output logic        err_flag,
  output logic [31:0] err_adr,
  output logic        err_we,
  output logic [15:0] err_count
`ifdef WB_TIMEOUT_IRQ_EN
  ,
  output logic        timeout_irq
`endif
);

  // Wait-counter width, derived from TIMEOUT.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last counter value at which a slave ack still completes normally.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_TOUT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req;
  logic             log_err;
  logic             in_tout;

  logic             err_flag_q, err_flag_d;
  logic [31:0]      err_adr_q, err_adr_d;
  logic             err_we_q, err_we_d;
  logic [15:0]      err_count_q, err_count_d;

  assign req     = m_cyc & m_stb;
  assign in_tout = (state_q == ST_TOUT);

  // Request/address/data pass straight through; only strobe/cycle are gated.
  assign s_adr   = m_adr;
  assign s_dat_o = m_dat_i;
  assign s_sel   = m_sel;
  assign s_we    = m_we;

  // Slave cycle is aborted during the error ack and held off while in reset.
  always_comb begin
    s_stb   = m_stb & ~in_tout & ~wb_rst;
    s_cyc   = m_cyc & ~in_tout & ~wb_rst;
    m_ack   = (in_tout | s_ack) & ~wb_rst;
    m_dat_o = in_tout ? ERR_DATA : s_dat_i;
  end

  // Next-state and wait-counter logic; a late ack on the last wait cycle wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    log_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !s_ack) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (s_ack || !req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_TOUT;
          cnt_d   = '0;
          log_err = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_TOUT: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status update: a logging edge beats a coincident clear (count restarts at 1).
  always_comb begin
    err_flag_d  = err_flag_q;
    err_adr_d   = err_adr_q;
    err_we_d    = err_we_q;
    err_count_d = err_count_q;
    if (log_err) begin
      err_flag_d  = 1'b1;
      err_adr_d   = m_adr;
      err_we_d    = m_we;
      if (err_clr)
        err_count_d = 16'd1;
      else if (err_count_q != 16'hFFFF)
        err_count_d = err_count_q + 16'd1;
    end else if (err_clr) begin
      err_flag_d  = 1'b0;
      err_count_d = 16'd0;
    end
  end

  // Sticky status registers.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      err_flag_q  <= 1'b0;
      err_adr_q   <= 32'd0;
      err_we_q    <= 1'b0;
      err_count_q <= 16'd0;
    end else begin
      err_flag_q  <= err_flag_d;
      err_adr_q   <= err_adr_d;
      err_we_q    <= err_we_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_adr   = err_adr_q;
  assign err_we    = err_we_q;
  assign err_count = err_count_q;

`ifdef WB_TIMEOUT_IRQ_EN
  logic irq_q, irq_d;

  // Interrupt follows the flag one cycle later and holds until a standalone clear.
  always_comb begin
    irq_d = irq_q | err_flag_q;
    if (err_clr && !log_err)
      irq_d = 1'b0;
  end

  // Interrupt register.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)
      irq_q <= 1'b0;
    else
      irq_q <= irq_d;
  end

  assign timeout_irq = irq_q;
`endif

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Testbench for wb_timeout_bridge (TIMEOUT=8): directed cases followed by
// randomized transactions, checked against a per-transaction outcome model.
module tb_wb_timeout_bridge;

  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int          NEVER    = 1000;

  logic        clk = 1'b0;
  logic        wb_rst;
  logic [31:0] m_adr, m_dat_i, m_dat_o, s_adr, s_dat_o, s_dat_i, err_adr;
  logic [3:0]  m_sel, s_sel;
  logic        m_we, m_stb, m_cyc, m_ack, s_we, s_stb, s_cyc, s_ack;
  logic        err_clr, err_flag, err_we;
  logic [15:0] err_count;
`ifdef WB_TIMEOUT_IRQ_EN
  logic        timeout_irq;
`endif

  int total = 0;
  int bad   = 0;

  // Reference status, updated from the outcome of each transaction.
  logic        mdl_flag  = 1'b0;
  logic [31:0] mdl_adr   = 32'd0;
  logic        mdl_we    = 1'b0;
  logic [15:0] mdl_count = 16'd0;
  logic        mdl_irq   = 1'b0;

  wb_timeout_bridge #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .wb_clk    (clk),
    .wb_rst    (wb_rst),
    .m_adr     (m_adr),
    .m_dat_i   (m_dat_i),
    .m_sel     (m_sel),
    .m_we      (m_we),
    .m_stb     (m_stb),
    .m_cyc     (m_cyc),
    .m_dat_o   (m_dat_o),
    .m_ack     (m_ack),
    .s_adr     (s_adr),
    .s_dat_o   (s_dat_o),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_stb     (s_stb),
    .s_cyc     (s_cyc),
    .s_dat_i   (s_dat_i),
    .s_ack     (s_ack),
    .err_clr   (err_clr),
    .err_flag  (err_flag),
    .err_adr   (err_adr),
    .err_we    (err_we),
    .err_count (err_count)
`ifdef WB_TIMEOUT_IRQ_EN
    ,
    .timeout_irq (timeout_irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".err_flag"},  32'(err_flag),  32'(mdl_flag));
    chk({tag, ".err_count"}, 32'(err_count), 32'(mdl_count));
    chk({tag, ".err_adr"},   err_adr,        mdl_adr);
    chk({tag, ".err_we"},    32'(err_we),    32'(mdl_we));
`ifdef WB_TIMEOUT_IRQ_EN
    chk({tag, ".irq"},       32'(timeout_irq), 32'(mdl_irq));
`endif
    $display("status %s: flag=%0b count=%0d adr=%h we=%0b", tag, err_flag, err_count, err_adr, err_we);
  endtask

  // Master idle for n cycles; nothing may be acked.
  task automatic idle(input int n);
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = 1'b0; err_clr = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle.m_ack", 32'(m_ack), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    mdl_flag = 1'b0; mdl_count = 16'd0; mdl_irq = 1'b0;
  endtask

  // One master request starting now (just after a rising edge).
  // lat: cycle in which the slave acks; drop: cycle in which the master
  // abandons; clr_at: cycle in which err_clr is pulsed.
  task automatic txn(input string tag, input logic [31:0] addr, input logic we,
                     input int lat, input int drop, input int clr_at, input logic [31:0] sdat);
    bit fin = 0;
    bit log_edge;
    int outcome_cyc = -1;
    m_adr = addr; m_we = we; m_sel = 4'($urandom); m_dat_i = $urandom;
    m_cyc = 1'b1; m_stb = 1'b1;
    for (int c = 0; c <= TIMEOUT && !fin; c++) begin
      err_clr = (c == clr_at);
      s_ack   = (c == lat);
      s_dat_i = sdat;
      if (c == drop) begin
        m_cyc = 1'b0; m_stb = 1'b0; s_ack = 1'b0;
      end
      @(negedge clk);
      if (c == drop) begin
        chk({tag, ".drop_ack"}, 32'(m_ack), 32'd0);
        fin = 1;
      end else if (c == lat && c < TIMEOUT) begin
        chk({tag, ".ack"},   32'(m_ack), 32'd1);
        chk({tag, ".rdat"},  m_dat_o,    sdat);
        chk({tag, ".s_cyc"}, 32'(s_cyc), 32'd1);
        fin = 1;
      end else if (c == TIMEOUT) begin
        chk({tag, ".err_ack"},  32'(m_ack), 32'd1);
        chk({tag, ".err_dat"},  m_dat_o,    ERR_DATA);
        chk({tag, ".abort_cyc"}, 32'({s_cyc, s_stb}), 32'd0);
        fin = 1;
      end else begin
        chk({tag, ".wait_ack"}, 32'(m_ack), 32'd0);
        chk({tag, ".pass_cyc"}, 32'({s_cyc, s_stb}), 32'd3);
        chk({tag, ".pass_adr"}, s_adr, addr);
        if (c == 0) chk({tag, ".pass_wd"}, {s_dat_o[27:0], s_sel}, {m_dat_i[27:0], m_sel});
      end
      if (fin) outcome_cyc = c;
      // Status effect of the clock edge closing cycle c.
      log_edge = (c == TIMEOUT - 1) && !fin;
      if (log_edge) begin
        mdl_flag = 1'b1; mdl_adr = addr; mdl_we = we; mdl_irq = 1'b1;
        if (c == clr_at)                mdl_count = 16'd1;
        else if (mdl_count != 16'hFFFF) mdl_count = mdl_count + 16'd1;
      end else if (c == clr_at) begin
        mdl_flag = 1'b0; mdl_count = 16'd0; mdl_irq = 1'b0;
      end
      @(posedge clk); #1;
    end
    err_clr = 1'b0; s_ack = 1'b0;
    $display("txn %s adr=%h we=%0b lat=%0d drop=%0d clr=%0d -> ended cycle %0d", tag, addr, we, lat, drop, clr_at, outcome_cyc);
  endtask

  initial begin
    // Reset with a request already driven: slave side must stay quiet.
    wb_rst = 1'b1; err_clr = 1'b0; s_ack = 1'b0; s_dat_i = 32'd0;
    m_adr = 32'h1000_0000; m_dat_i = 32'd0; m_sel = 4'hF; m_we = 1'b0;
    m_cyc = 1'b1; m_stb = 1'b1;
    #12;
    chk("rst.m_ack", 32'(m_ack), 32'd0);
    chk("rst.s_cyc", 32'({s_cyc, s_stb}), 32'd0);
    check_status("rst");
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk); wb_rst = 1'b0;
    @(posedge clk); #1;

    // Mapped read acked in cycle 2.
    txn("mapped", 32'h3000_0004, 1'b0, 2, NEVER, -1, 32'h1234_5678);
    idle(2);
    check_status("mapped");

    // Unmapped read times out.
    txn("unmapped", 32'h3010_0000, 1'b0, NEVER, NEVER, -1, 32'h0);
    idle(2);
    check_status("unmapped");

    // Late ack on the last wait cycle completes normally; one cycle later it is ignored.
    txn("ack7", 32'h3000_0010, 1'b1, 7, NEVER, -1, 32'hCAFE_0007);
    idle(1);
    check_status("ack7");
    txn("ack8", 32'h3000_0020, 1'b1, 8, NEVER, -1, 32'hCAFE_0008);
    idle(1);
    check_status("ack8");

    // Master abandons a stalled cycle: no ack, no error.
    do_clr();
    check_status("clr");
    txn("drop5", 32'h3000_0030, 1'b0, NEVER, 5, -1, 32'h0);
    idle(TIMEOUT);
    check_status("drop5");

    // Two timeouts, then a clear coinciding with the third logging edge.
    txn("to1", 32'h3100_0000, 1'b0, NEVER, NEVER, -1, 32'h0);
    txn("to2", 32'h3200_0000, 1'b1, NEVER, NEVER, -1, 32'h0);
    idle(1);
    check_status("to2");
    txn("to3clr", 32'h3300_0000, 1'b0, NEVER, NEVER, TIMEOUT - 1, 32'h0);
    idle(1);
    check_status("to3clr");
    do_clr();
    check_status("clr2");

    // Back-to-back: timeout immediately followed by a request that is acked.
    txn("b2b_to", 32'h3400_0000, 1'b1, NEVER, NEVER, -1, 32'h0);
    txn("b2b_ok", 32'h3400_0004, 1'b0, 3, NEVER, -1, 32'h5555_AAAA);
    txn("b2b_to2", 32'h3400_0008, 1'b0, NEVER, NEVER, -1, 32'h0);
    idle(1);
    check_status("b2b");

    // Reset pulsed in cycle 4 of a stalled request.
    m_adr = 32'h3500_0000; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1; s_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    wb_rst = 1'b1;
    #1;
    mdl_flag = 1'b0; mdl_count = 16'd0; mdl_adr = 32'd0; mdl_we = 1'b0; mdl_irq = 1'b0;
    chk("midrst.m_ack", 32'(m_ack), 32'd0);
    chk("midrst.s_cyc", 32'({s_cyc, s_stb}), 32'd0);
    check_status("midrst");
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk); wb_rst = 1'b0;
    @(posedge clk); #1;
    idle(TIMEOUT + 2);
    txn("postrst", 32'h3600_0000, 1'b1, NEVER, NEVER, -1, 32'h0);
    idle(1);
    check_status("postrst");

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      int lat, drop, clr_at;
      lat    = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT + 1));
      drop   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : NEVER;
      clr_at = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, TIMEOUT)) : -1;
      txn("rand", $urandom, 1'($urandom), lat, drop, clr_at, $urandom);
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
      check_status("rand");
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
